// File: rtl/duc_core_if.sv
// rtl/duc_core_if.sv - sample, config, DDS and output signal bundle for duc_core
interface duc_core_if #(
  parameter int PHASE_W = 32
) ();
  logic [31:0]        data_in;
  logic               valid_in;
  logic               cfg_valid;
  logic [PHASE_W-1:0] pinc;
  logic [PHASE_W-1:0] poff;
  logic               resync;
  logic [PHASE_W-1:0] phase_out;
  logic               phase_valid;
  logic [31:0]        dds_in;
  logic               dds_valid;
  logic [31:0]        data_out;
  logic               valid_out;
  logic               align_err;

  modport slave (
    input  data_in, valid_in, cfg_valid, pinc, poff, resync, dds_in, dds_valid,
    output phase_out, phase_valid, data_out, valid_out, align_err
  );

  modport master (
    output data_in, valid_in, cfg_valid, pinc, poff, resync, dds_in, dds_valid,
    input  phase_out, phase_valid, data_out, valid_out, align_err
  );
endinterface

// File: rtl/duc_core.sv
// rtl/duc_core.sv - digital up-converter: phase generation, DDS alignment, complex mix
module duc_core #(
  parameter int PHASE_W = 32,
  parameter int DDS_LAT = 8
) (
  input logic       clk,
  input logic       rst,
  duc_core_if.slave bus
);

  localparam int DLY = DDS_LAT + 1;

  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] pinc_r;
  logic [PHASE_W-1:0] poff_r;

  logic [31:0]    dly_data [DLY];
  logic [DLY-1:0] dly_valid;

  logic signed [15:0] d_i, d_q, d_cos, d_sin;
  logic signed [31:0] p_icos, p_qsin, p_isin, p_qcos;
  logic               m_valid;
  logic signed [32:0] s_i, s_q;
  logic               a_valid;

  assign d_i   = dly_data[DLY-1][15:0];
  assign d_q   = dly_data[DLY-1][31:16];
  assign d_cos = bus.dds_in[15:0];
  assign d_sin = bus.dds_in[31:16];

  // Round half up by 2^15 then clamp to the signed 16-bit range.
  function automatic logic [15:0] round_sat(input logic signed [32:0] s);
    logic signed [33:0] t;
    t = {s[32], s} + 34'sd16384;
    t = t >>> 15;
    if (t > 34'sd32767)
      return 16'h7fff;
    else if (t < -34'sd32768)
      return 16'h8000;
    else
      return t[15:0];
  endfunction

  // Phase accumulator and config; a config load lands after any same-cycle sample, resync wins over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc             <= '0;
      pinc_r          <= '0;
      poff_r          <= '0;
      bus.phase_out   <= '0;
      bus.phase_valid <= 1'b0;
    end else begin
      if (bus.valid_in) begin
        bus.phase_out   <= acc + poff_r;
        acc             <= acc + pinc_r;
        bus.phase_valid <= 1'b1;
      end else begin
        bus.phase_valid <= 1'b0;
      end
      if (bus.cfg_valid) begin
        pinc_r <= bus.pinc;
        poff_r <= bus.poff;
        if (bus.resync)
          acc <= '0;
      end
    end
  end

  // Delay samples so each one meets the DDS word generated from its own phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      dly_valid <= '0;
      for (int i = 0; i < DLY; i++)
        dly_data[i] <= '0;
    end else begin
      dly_valid   <= {dly_valid[DLY-2:0], bus.valid_in};
      dly_data[0] <= bus.data_in;
      for (int i = 1; i < DLY; i++)
        dly_data[i] <= dly_data[i-1];
    end
  end

  // Sticky flag when the DDS strobe and the delayed sample strobe disagree.
  always_ff @(posedge clk) begin
    if (rst)
      bus.align_err <= 1'b0;
    else if (dly_valid[DLY-1] != bus.dds_valid)
      bus.align_err <= 1'b1;
  end

  // Multiply stage: four partial products of the complex mix.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_icos  <= '0;
      p_qsin  <= '0;
      p_isin  <= '0;
      p_qcos  <= '0;
      m_valid <= 1'b0;
    end else begin
      m_valid <= dly_valid[DLY-1];
      if (dly_valid[DLY-1]) begin
        p_icos <= d_i * d_cos;
        p_qsin <= d_q * d_sin;
        p_isin <= d_i * d_sin;
        p_qcos <= d_q * d_cos;
      end
    end
  end

  // Add stage: full-precision real and imaginary sums.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_i     <= '0;
      s_q     <= '0;
      a_valid <= 1'b0;
    end else begin
      a_valid <= m_valid;
      if (m_valid) begin
        s_i <= {p_icos[31], p_icos} - {p_qsin[31], p_qsin};
        s_q <= {p_isin[31], p_isin} + {p_qcos[31], p_qcos};
      end
    end
  end

  // Output stage: round, saturate, hold the last sample while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.data_out  <= '0;
      bus.valid_out <= 1'b0;
    end else begin
      bus.valid_out <= a_valid;
      if (a_valid)
        bus.data_out <= {round_sat(s_q), round_sat(s_i)};
    end
  end

endmodule

// File: tb/tb_duc_core.sv
// tb/tb_duc_core.sv - directed self-checking bench for duc_core
module tb_duc_core;

  logic clk;
  logic rst;
  logic kill;
  logic [7:0] dds_pipe;

  int checks;
  int failures;

  logic [5:0]  pat;
  logic [16:0] ph_cap;
  logic [16:0] vo_cap;
  logic        seen;

  duc_core_if #(.PHASE_W(32)) bus ();

  duc_core #(.PHASE_W(32), .DDS_LAT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DDS stand-in: fixed 8-cycle strobe latency, optional strobe suppression.
  always @(posedge clk) begin
    if (rst)
      dds_pipe <= '0;
    else
      dds_pipe <= {dds_pipe[6:0], bus.phase_valid};
  end
  assign bus.dds_valid = dds_pipe[7] & ~kill;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    kill = 1'b0;
    rst = 1'b1;
    bus.data_in = '0;
    bus.valid_in = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.pinc = '0;
    bus.poff = '0;
    bus.resync = 1'b0;
    bus.dds_in = '0;
    tick();
    tick();
    check("rst_phase_out", 64'(bus.phase_out), 64'h0);
    check("rst_phase_valid", 64'(bus.phase_valid), 64'h0);
    check("rst_data_out", 64'(bus.data_out), 64'h0);
    check("rst_valid_out", 64'(bus.valid_out), 64'h0);
    check("rst_align_err", 64'(bus.align_err), 64'h0);
    rst = 1'b0;
    tick();

    // Test 1: unity carrier, latency of exactly 12 cycles
    bus.dds_in = 32'h0000_7fff;
    bus.data_in = 32'hF830_03E8;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    check("t1_lat_k1", 64'(bus.valid_out), 64'h0);
    for (int k = 2; k <= 12; k++) begin
      tick();
      check($sformatf("t1_lat_k%0d", k), 64'(bus.valid_out), (k == 12) ? 64'h1 : 64'h0);
    end
    check("t1_data", 64'(bus.data_out), 64'hF830_03E8);
    tick();
    check("t1_vo_drop", 64'(bus.valid_out), 64'h0);
    check("t1_hold", 64'(bus.data_out), 64'hF830_03E8);
    check("t1_align", 64'(bus.align_err), 64'h0);

    // Test 2: full-scale negative corner, Q saturates
    bus.dds_in = 32'h8000_8000;
    bus.data_in = 32'h8000_8000;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    repeat (11) tick();
    check("t2_valid", 64'(bus.valid_out), 64'h1);
    check("t2_sat", 64'(bus.data_out), 64'h7FFF_0000);

    // Test 3: phase increment/offset, resync, same-cycle config uses old pinc
    bus.cfg_valid = 1'b1;
    bus.pinc = 32'h1000_0000;
    bus.poff = 32'h4000_0000;
    bus.resync = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    bus.resync = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.valid_in = 1'b1;
      tick();
      check($sformatf("t3_phase%0d", i), 64'(bus.phase_out), 64'(32'h4000_0000 + 32'(i) * 32'h1000_0000));
    end
    bus.valid_in = 1'b0;
    bus.cfg_valid = 1'b1;
    bus.resync = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    bus.resync = 1'b0;
    bus.valid_in = 1'b1;
    tick();
    check("t3_resync2", 64'(bus.phase_out), 64'h4000_0000);
    bus.cfg_valid = 1'b1;
    bus.pinc = 32'h0100_0000;
    tick();
    bus.cfg_valid = 1'b0;
    check("t3_samecyc", 64'(bus.phase_out), 64'h5000_0000);
    tick();
    check("t3_oldpinc", 64'(bus.phase_out), 64'h6000_0000);
    tick();
    check("t3_newpinc", 64'(bus.phase_out), 64'h6100_0000);
    bus.valid_in = 1'b0;
    tick();
    check("t3_pv_low", 64'(bus.phase_valid), 64'h0);
    check("t3_ph_hold", 64'(bus.phase_out), 64'h6100_0000);
    repeat (14) tick();
    check("t3_align", 64'(bus.align_err), 64'h0);

    // Test 4: gapped valid pattern 1,0,1,1,0,1
    bus.cfg_valid = 1'b1;
    bus.pinc = 32'h1000_0000;
    bus.poff = 32'h0;
    bus.resync = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    bus.resync = 1'b0;
    pat = 6'b101101;
    for (int i = 0; i < 17; i++) begin
      bus.valid_in = (i < 6) ? pat[i] : 1'b0;
      tick();
      ph_cap[i] = bus.phase_valid;
      vo_cap[i] = bus.valid_out;
    end
    check("t4_phase_valid", 64'(ph_cap), 64'({11'b0, pat}));
    check("t4_valid_out", 64'(vo_cap), 64'({pat, 11'b0}));
    check("t4_phase_last", 64'(bus.phase_out), 64'h3000_0000);
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    check("t4_phase_next", 64'(bus.phase_out), 64'h4000_0000);
    repeat (14) tick();
    check("t4_align", 64'(bus.align_err), 64'h0);

    // Test 5: missing DDS strobe raises sticky align_err
    kill = 1'b1;
    bus.data_in = 32'h0100_0100;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    for (int k = 2; k <= 12; k++) begin
      tick();
      if (k == 9)
        check("t5_err_before", 64'(bus.align_err), 64'h0);
      if (k == 10)
        check("t5_err_set", 64'(bus.align_err), 64'h1);
      if (k == 12)
        check("t5_still_runs", 64'(bus.valid_out), 64'h1);
    end
    check("t5_data", 64'(bus.data_out), 64'hFE00_0000);
    kill = 1'b0;
    repeat (5) tick();
    check("t5_sticky", 64'(bus.align_err), 64'h1);

    // Test 6: reset with samples in flight
    bus.data_in = 32'h1234_5678;
    bus.valid_in = 1'b1;
    repeat (5) tick();
    bus.valid_in = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_phase_out", 64'(bus.phase_out), 64'h0);
    check("t6_phase_valid", 64'(bus.phase_valid), 64'h0);
    check("t6_data_out", 64'(bus.data_out), 64'h0);
    check("t6_valid_out", 64'(bus.valid_out), 64'h0);
    check("t6_align_err", 64'(bus.align_err), 64'h0);
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (bus.valid_out)
        seen = 1'b1;
    end
    check("t6_no_stale", 64'(seen), 64'h0);
    check("t6_align_after", 64'(bus.align_err), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
